// File: rtl/router_pkg.sv
// router_pkg: packet field layout and FIFO word sizing shared by router port logic.
package router_pkg;
   localparam int PKT_WIDTH       = 64;
   localparam int CHILDREN_WIDTH  = 3;
   localparam int FIFO_WORD_WIDTH = PKT_WIDTH + CHILDREN_WIDTH;
   localparam int CHILDREN_POS    = PKT_WIDTH;
   localparam int VALID_BIT_POS   = 63;
   localparam int OP_POS          = 60;
   localparam int OP_WIDTH        = 3;
   localparam int SRC_POS         = 48;
   localparam int SRC_WIDTH       = 12;
   localparam int DST_POS         = 36;
   localparam int DST_WIDTH       = 12;
   localparam int PAYLOAD_WIDTH   = 36;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_NOP    = 3'd0,
      OP_UNI    = 3'd1,
      OP_REDUCE = 3'd2,
      OP_BCAST  = 3'd3
   } pkt_op_e;

   typedef struct packed {
      logic [CHILDREN_WIDTH-1:0] children;
      logic                      valid;
      pkt_op_e                   op;
      logic [SRC_WIDTH-1:0]      src;
      logic [DST_WIDTH-1:0]      dst;
      logic [PAYLOAD_WIDTH-1:0]  payload;
   } fifo_word_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointers, occupancy counter, status flags and accept logic for pkt_peek_fifo.
// Optional `FIFO_STATS_EN adds high-water mark and overflow/underflow sticky flags.
module fifo_ptr_ctrl #(
   parameter int FifoLgSize       = 4,
   parameter int AlmostFullThresh = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  pass,
   output logic [FifoLgSize-1:0] rd_ptr,
   output logic [FifoLgSize-1:0] wr_ptr,
   output logic [FifoLgSize:0]   fifo_counter,
   output logic                  do_rd,
   output logic                  do_wr,
   output logic                  buf_empty,
   output logic                  buf_full,
   output logic                  almost_full,
   output logic                  next_valid,
   output logic                  wr_drop
`ifdef FIFO_STATS_EN
   ,
   output logic [FifoLgSize:0]   hwm_out,
   output logic                  ovf_sticky,
   output logic                  unf_sticky
`endif
);
   localparam logic [FifoLgSize:0]   DEPTH = (FifoLgSize+1)'(1 << FifoLgSize);
   localparam logic [FifoLgSize:0]   AF    = (FifoLgSize+1)'(AlmostFullThresh);
   localparam logic [FifoLgSize:0]   CONE  = (FifoLgSize+1)'(1);
   localparam logic [FifoLgSize-1:0] PONE  = FifoLgSize'(1);

   logic [FifoLgSize:0] count_nxt;

   always_comb begin
      buf_empty   = fifo_counter == '0;
      buf_full    = fifo_counter == DEPTH;
      almost_full = fifo_counter >= AF;
      next_valid  = fifo_counter > CONE;
      do_rd       = rd_en & ~buf_empty;
      // a pop in the same cycle frees the slot a full FIFO needs for the push
      do_wr       = wr_en & pass & (~buf_full | do_rd);
      count_nxt   = (do_wr & ~do_rd) ? fifo_counter + CONE :
                    (do_rd & ~do_wr) ? fifo_counter - CONE : fifo_counter;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         fifo_counter <= '0;
         wr_drop      <= 1'b0;
      end else begin
         if (do_rd) rd_ptr <= rd_ptr + PONE;
         if (do_wr) wr_ptr <= wr_ptr + PONE;
         fifo_counter <= count_nxt;
         wr_drop      <= wr_en & ~do_wr;
      end
   end

`ifdef FIFO_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hwm_out    <= '0;
         ovf_sticky <= 1'b0;
         unf_sticky <= 1'b0;
      end else begin
         if (count_nxt > hwm_out) hwm_out <= count_nxt;
         if (wr_en & pass & buf_full & ~do_rd) ovf_sticky <= 1'b1;
         if (rd_en & buf_empty) unf_sticky <= 1'b1;
      end
   end
`endif
endmodule

// File: rtl/pkt_peek_fifo.sv
// pkt_peek_fifo: FWFT packet FIFO exposing head and next word, with almost-full and invalid-write filter.
// Optional `FIFO_STATS_EN adds hwm_out, ovf_sticky and unf_sticky.
module pkt_peek_fifo
   import router_pkg::*;
#(
   parameter int DataWidth        = FIFO_WORD_WIDTH,
   parameter int FifoLgSize       = 4,
   parameter int AlmostFullThresh = 12,
   parameter int ValidBitPos      = VALID_BIT_POS,
   parameter int FilterInvalid    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DataWidth-1:0] buf_in,
   input  logic                 wr_en,
   input  logic                 rd_en,
   output logic [DataWidth-1:0] head_out,
   output logic                 head_valid,
   output logic [DataWidth-1:0] next_out,
   output logic                 next_valid,
   output logic                 buf_empty,
   output logic                 buf_full,
   output logic                 almost_full,
   output logic [FifoLgSize:0]  fifo_counter,
   output logic                 wr_drop
`ifdef FIFO_STATS_EN
   ,
   output logic [FifoLgSize:0]  hwm_out,
   output logic                 ovf_sticky,
   output logic                 unf_sticky
`endif
);
   localparam int DEPTH = 1 << FifoLgSize;

   logic [DataWidth-1:0]  mem [DEPTH];
   logic [FifoLgSize-1:0] rd_ptr, wr_ptr, nxt_ptr;
   logic                  pass, do_rd, do_wr;

   assign pass = (FilterInvalid == 0) | buf_in[ValidBitPos];

   fifo_ptr_ctrl #(
      .FifoLgSize      (FifoLgSize),
      .AlmostFullThresh(AlmostFullThresh)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .pass        (pass),
      .rd_ptr      (rd_ptr),
      .wr_ptr      (wr_ptr),
      .fifo_counter(fifo_counter),
      .do_rd       (do_rd),
      .do_wr       (do_wr),
      .buf_empty   (buf_empty),
      .buf_full    (buf_full),
      .almost_full (almost_full),
      .next_valid  (next_valid),
      .wr_drop     (wr_drop)
`ifdef FIFO_STATS_EN
      ,
      .hwm_out     (hwm_out),
      .ovf_sticky  (ovf_sticky),
      .unf_sticky  (unf_sticky)
`endif
   );

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= buf_in;
   end

   // gating keeps uninitialised storage from leaking X after reset
   always_comb begin
      nxt_ptr    = rd_ptr + FifoLgSize'(1);
      head_valid = ~buf_empty;
      head_out   = head_valid ? mem[rd_ptr] : '0;
      next_out   = next_valid ? mem[nxt_ptr] : '0;
   end
endmodule

// File: tb/tb_pkt_peek_fifo.sv
// tb_pkt_peek_fifo: directed and scoreboard checks for pkt_peek_fifo (filtering and non-filtering instances).
module tb_pkt_peek_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [66:0] buf_in = '0;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [66:0] head_out, next_out, head2, next2;
   logic        head_valid, next_valid, buf_empty, buf_full, almost_full, wr_drop;
   logic        hv2, nv2, be2, bf2, af2, wd2;
   logic [4:0]  fifo_counter, cnt2;
`ifdef FIFO_STATS_EN
   logic [4:0]  hwm_out, hwm2;
   logic        ovf_sticky, unf_sticky, ovf2, unf2;
`endif
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pkt_peek_fifo dut (
      .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
      .head_out(head_out), .head_valid(head_valid), .next_out(next_out), .next_valid(next_valid),
      .buf_empty(buf_empty), .buf_full(buf_full), .almost_full(almost_full),
      .fifo_counter(fifo_counter), .wr_drop(wr_drop)
`ifdef FIFO_STATS_EN
      , .hwm_out(hwm_out), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
`endif
   );

   pkt_peek_fifo #(.FilterInvalid(0)) dut_nf (
      .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
      .head_out(head2), .head_valid(hv2), .next_out(next2), .next_valid(nv2),
      .buf_empty(be2), .buf_full(bf2), .almost_full(af2),
      .fifo_counter(cnt2), .wr_drop(wd2)
`ifdef FIFO_STATS_EN
      , .hwm_out(hwm2), .ovf_sticky(ovf2), .unf_sticky(unf2)
`endif
   );

   function automatic logic [66:0] mk(input int i);
      return {3'(i), 1'b1, 63'(64'h0ABC_0000_0000 + 64'(i))};
   endfunction

   task automatic cyc(input logic w, input logic r, input logic [66:0] d);
      wr_en = w; rd_en = r; buf_in = d;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1; #1;
      checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", buf_empty); end
      checks++; if (fifo_counter !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_counter); end
      checks++; if ({head_valid, next_valid, buf_full, almost_full, wr_drop} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b want 00000", {head_valid, next_valid, buf_full, almost_full, wr_drop}); end
      checks++; if (head_out !== '0 || next_out !== '0) begin errors++; $display("FAIL rst_data got %h/%h want 0/0", head_out, next_out); end
`ifdef FIFO_STATS_EN
      checks++; if ({hwm_out, ovf_sticky, unf_sticky} !== 7'b0) begin errors++; $display("FAIL rst_stats got %b want 0", {hwm_out, ovf_sticky, unf_sticky}); end
`endif
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_basic;
      test_reset();
      cyc(1'b1, 1'b0, mk(1));
      checks++; if (head_out !== mk(1) || next_valid !== 1'b0 || next_out !== '0) begin errors++; $display("FAIL basic_one got head=%h nv=%b next=%h want head=%h nv=0 next=0", head_out, next_valid, next_out, mk(1)); end
      cyc(1'b1, 1'b0, mk(2));
      cyc(1'b1, 1'b0, mk(3));
      checks++; if (head_out !== mk(1)) begin errors++; $display("FAIL basic_head got %h want %h", head_out, mk(1)); end
      checks++; if (next_out !== mk(2)) begin errors++; $display("FAIL basic_next got %h want %h", next_out, mk(2)); end
      checks++; if (fifo_counter !== 5'd3) begin errors++; $display("FAIL basic_count got %0d want 3", fifo_counter); end
      checks++; if ({head_valid, next_valid} !== 2'b11) begin errors++; $display("FAIL basic_valid got %b want 11", {head_valid, next_valid}); end
      cyc(1'b0, 1'b1, '0);
      checks++; if (head_out !== mk(2) || next_out !== mk(3)) begin errors++; $display("FAIL basic_pop got %h/%h want %h/%h", head_out, next_out, mk(2), mk(3)); end
   endtask

   task automatic test_full;
      test_reset();
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, mk(i));
         checks++; if (almost_full !== (i >= 11)) begin errors++; $display("FAIL full_af count=%0d got %b want %b", i + 1, almost_full, i >= 11); end
         checks++; if (buf_full !== (i == 15)) begin errors++; $display("FAIL full_flag count=%0d got %b want %b", i + 1, buf_full, i == 15); end
      end
      cyc(1'b1, 1'b0, mk(99));
      checks++; if (wr_drop !== 1'b1 || fifo_counter !== 5'd16) begin errors++; $display("FAIL full_drop got drop=%b cnt=%0d want 1/16", wr_drop, fifo_counter); end
      checks++; if (head_out !== mk(0)) begin errors++; $display("FAIL full_head got %h want %h", head_out, mk(0)); end
`ifdef FIFO_STATS_EN
      checks++; if (ovf_sticky !== 1'b1 || hwm_out !== 5'd16) begin errors++; $display("FAIL full_stats got ovf=%b hwm=%0d want 1/16", ovf_sticky, hwm_out); end
`endif
      cyc(1'b1, 1'b1, mk(100));
      checks++; if (fifo_counter !== 5'd16 || wr_drop !== 1'b0 || head_out !== mk(1)) begin errors++; $display("FAIL full_pushpop got cnt=%0d drop=%b head=%h want 16/0/%h", fifo_counter, wr_drop, head_out, mk(1)); end
      for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, '0);
      checks++; if (head_out !== mk(100) || fifo_counter !== 5'd1) begin errors++; $display("FAIL full_tail got head=%h cnt=%0d want %h/1", head_out, fifo_counter, mk(100)); end
   endtask

   task automatic test_empty;
      test_reset();
      cyc(1'b1, 1'b1, mk(7));
      checks++; if (fifo_counter !== 5'd1 || head_out !== mk(7)) begin errors++; $display("FAIL empty_pushpop got cnt=%0d head=%h want 1/%h", fifo_counter, head_out, mk(7)); end
      cyc(1'b0, 1'b1, '0);
      cyc(1'b0, 1'b1, '0);
      checks++; if (fifo_counter !== 5'd0 || head_out !== '0 || buf_empty !== 1'b1 || wr_drop !== 1'b0) begin errors++; $display("FAIL empty_pop got cnt=%0d head=%h empty=%b drop=%b want 0/0/1/0", fifo_counter, head_out, buf_empty, wr_drop); end
`ifdef FIFO_STATS_EN
      checks++; if (unf_sticky !== 1'b1 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL empty_unf got unf=%b ovf=%b want 1/0", unf_sticky, ovf_sticky); end
`endif
   endtask

   task automatic test_filter;
      logic [66:0] bad;
      test_reset();
      bad = mk(5);
      bad[63] = 1'b0;
      cyc(1'b1, 1'b0, bad);
      checks++; if (fifo_counter !== 5'd0 || wr_drop !== 1'b1) begin errors++; $display("FAIL filter_drop got cnt=%0d drop=%b want 0/1", fifo_counter, wr_drop); end
      checks++; if (cnt2 !== 5'd1 || head2 !== bad || wd2 !== 1'b0) begin errors++; $display("FAIL filter_off got cnt=%0d head=%h drop=%b want 1/%h/0", cnt2, head2, wd2, bad); end
      cyc(1'b0, 1'b0, '0);
      checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL filter_pulse got %b want 0", wr_drop); end
   endtask

   task automatic test_random;
      logic [66:0] q[$];
      logic        w, r, mrd, mwr;
      logic [66:0] eh, en;
      test_reset();
      for (int i = 0; i < 40; i++) begin
         w = $urandom_range(0, 3) != 0;
         r = $urandom_range(0, 1) != 0;
         mrd = r && q.size() > 0;
         mwr = w && (q.size() < 16 || mrd);
         cyc(w, r, mk(200 + i));
         if (mrd) void'(q.pop_front());
         if (mwr) q.push_back(mk(200 + i));
         eh = q.size() > 0 ? q[0] : '0;
         en = q.size() > 1 ? q[1] : '0;
         checks++; if (head_out !== eh) begin errors++; $display("FAIL rand_head cyc=%0d got %h want %h", i, head_out, eh); end
         checks++; if (next_out !== en) begin errors++; $display("FAIL rand_next cyc=%0d got %h want %h", i, next_out, en); end
         checks++; if (fifo_counter !== 5'(q.size())) begin errors++; $display("FAIL rand_count cyc=%0d got %0d want %0d", i, fifo_counter, q.size()); end
      end
      test_reset();
      cyc(1'b1, 1'b0, mk(300));
      checks++; if (head_out !== mk(300) || fifo_counter !== 5'd1) begin errors++; $display("FAIL post_rst got head=%h cnt=%0d want %h/1", head_out, fifo_counter, mk(300)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_empty();
      test_filter();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
